// File: rtl/lockstep_pkg.sv
// lockstep_pkg: shared types and sizes for the dual-core lockstep checker.
package lockstep_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int XLEN       = 32;
    typedef enum logic [1:0] {RUN, HALT, RESTORE, RESUME} state_e;
endpackage

// File: rtl/lockstep_if.sv
// lockstep_if: commit streams of both cores and the checker's recovery outputs.
interface lockstep_if
    import lockstep_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic                  c0_rf_we_i, c1_rf_we_i;
    logic [REG_ADDR_W-1:0] c0_rf_waddr_i, c1_rf_waddr_i;
    logic [XLEN-1:0]       c0_rf_wdata_i, c1_rf_wdata_i;
    logic                  c0_pc_valid_i, c1_pc_valid_i;
    logic [XLEN-1:0]       c0_pc_i, c1_pc_i;
    logic                  error_o;
    logic [CNT_W-1:0]      error_count_o;
    logic                  halt_o;
    logic                  restore_we_o;
    logic [REG_ADDR_W-1:0] restore_addr_o;
    logic [XLEN-1:0]       restore_data_o;
    logic                  pc_restore_valid_o;
    logic [XLEN-1:0]       pc_restore_o;
    modport slave (
        input  c0_rf_we_i, c1_rf_we_i, c0_rf_waddr_i, c1_rf_waddr_i,
               c0_rf_wdata_i, c1_rf_wdata_i, c0_pc_valid_i, c1_pc_valid_i, c0_pc_i, c1_pc_i,
        output error_o, error_count_o, halt_o, restore_we_o, restore_addr_o,
               restore_data_o, pc_restore_valid_o, pc_restore_o
    );
    modport master (
        output c0_rf_we_i, c1_rf_we_i, c0_rf_waddr_i, c1_rf_waddr_i,
               c0_rf_wdata_i, c1_rf_wdata_i, c0_pc_valid_i, c1_pc_valid_i, c0_pc_i, c1_pc_i,
        input  error_o, error_count_o, halt_o, restore_we_o, restore_addr_o,
               restore_data_o, pc_restore_valid_o, pc_restore_o
    );
endinterface

// File: rtl/shadow_regfile.sv
// shadow_regfile: golden copy of registers x1..x31; x0 reads as zero.
module shadow_regfile
    import lockstep_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic [XLEN-1:0]       wdata_i,
    input  logic [REG_ADDR_W-1:0] raddr_i,
    output logic [XLEN-1:0]       rdata_o
);
    logic [XLEN-1:0] regs_q [1:NUM_REGS-1];
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (we_i && waddr_i != '0) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end
    assign rdata_o = raddr_i == '0 ? '0 : regs_q[raddr_i];
endmodule

// File: rtl/lockstep_checker.sv
// lockstep_checker: compares two cores' commits; on divergence halts both,
// replays the shadow register file and reloads the last agreed PC.
module lockstep_checker
    import lockstep_pkg::*;
#(
    parameter logic [XLEN-1:0] BOOT_ADDR = 32'h0000_0080,
    parameter int              CNT_W     = 16
) (
    input logic       clk_i,
    input logic       rst_ni,
    lockstep_if.slave bus
);
    state_e                state_q, state_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       ckpt_q, ckpt_d, rdata;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic run, we_both, pv_both, wr_match, pc_match, mismatch, commit, restoring;

    assign run      = state_q == RUN;
    assign we_both  = bus.c0_rf_we_i && bus.c1_rf_we_i;
    assign pv_both  = bus.c0_pc_valid_i && bus.c1_pc_valid_i;
    assign wr_match = bus.c0_rf_waddr_i == bus.c1_rf_waddr_i && bus.c0_rf_wdata_i == bus.c1_rf_wdata_i;
    assign pc_match = bus.c0_pc_i == bus.c1_pc_i;
    assign mismatch = run && (bus.c0_rf_we_i != bus.c1_rf_we_i || (we_both && !wr_match) ||
                              bus.c0_pc_valid_i != bus.c1_pc_valid_i || (pv_both && !pc_match));
    // An agreed write still lands even when the PCs diverge in the same cycle.
    assign commit   = run && we_both && wr_match;

    shadow_regfile u_shadow (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (commit),
        .waddr_i (bus.c0_rf_waddr_i),
        .wdata_i (bus.c0_rf_wdata_i),
        .raddr_i (addr_q),
        .rdata_o (rdata)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ckpt_d  = run && pv_both && pc_match ? bus.c0_pc_i : ckpt_q;
        cnt_d   = mismatch && cnt_q != '1 ? cnt_q + 1'b1 : cnt_q;
        case (state_q)
            RUN:     state_d = mismatch ? HALT : RUN;
            HALT: begin
                state_d = RESTORE;
                addr_d  = REG_ADDR_W'(1);
            end
            RESTORE: begin
                addr_d  = addr_q + 1'b1;
                state_d = addr_q == REG_ADDR_W'(NUM_REGS - 1) ? RESUME : RESTORE;
            end
            RESUME:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            addr_q  <= '0;
            ckpt_q  <= BOOT_ADDR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ckpt_q  <= ckpt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign restoring              = state_q == RESTORE;
    assign bus.error_o            = state_q == HALT;
    assign bus.halt_o             = !run;
    assign bus.restore_we_o       = restoring;
    assign bus.restore_addr_o     = restoring ? addr_q : '0;
    assign bus.restore_data_o     = restoring ? rdata : '0;
    assign bus.pc_restore_valid_o = state_q == RESUME;
    assign bus.pc_restore_o       = ckpt_q;
    assign bus.error_count_o      = cnt_q;
endmodule
